cpu_ctrl_fsm: RTL and testbench

Multicycle control unit of the RV32I core. Sequences each instruction through FETCH, DECODE, EXECUTE, MEM_ACC and RFL_WRB using the `cpu_state_t` encoding. Decodes the instruction register's opcode/funct fields and drives the datapath enables, mux selects and `alu_opcode_t`. Sits between the instruction register/memory interface and the datapath (PC, register file, ALU).

---
 rtl/cpu_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit of the RV32I core.
// Sequences FETCH/DECODE/EXECUTE/MEM_ACC/RFL_WRB and decodes datapath controls.
// Optional feature: define CPU_ILLEGAL_INSTR_TRAP_EN to trap unknown opcodes and
// unsupported R-type funct3 in DECODE with a sticky illegal_instr flag.

package pkg_cpu_typedefs;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM_ACC = 3'd3,
      RFL_WRB = 3'd4
   } cpu_state_t;

   typedef enum logic [6:0] {
      R_TYPE = 7'b0110011,
      I_TYPE = 7'b0010011,
      LOAD   = 7'b0000011,
      S_TYPE = 7'b0100011,
      B_TYPE = 7'b1100011,
      J_TYPE = 7'b1101111,
      JALR   = 7'b1100111,
      LUI    = 7'b0110111,
      AUI_PC = 7'b0010111
   } cpu_opcode_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_opcode_t;

endpackage

module cpu_ctrl_fsm
   import pkg_cpu_typedefs::*;
(
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   input  logic       alu_zero,
   input  logic       mem_rdy,
   output logic [2:0] state,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_src,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] result_src
`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
   ,
   output logic       illegal_instr
`endif
);

   cpu_state_t state_q;
   cpu_state_t state_d;
   logic       br_taken;

   // ALU operation for R/I-type arithmetic; SUB only for R-type with bit 30 set
   function automatic alu_opcode_t alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7);
      alu_opcode_t res;
      case (f3)
         3'b000:  res = (op == R_TYPE && f7) ? ALU_SUB : ALU_ADD;
         3'b111:  res = ALU_AND;
         3'b110:  res = ALU_OR;
         3'b010:  res = ALU_SLT;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
   logic illegal_q;
   logic illegal_d;
   logic illegal_dec;

   // Flag opcodes outside the supported set and R-type funct3 the ALU cannot do
   always_comb begin
      illegal_dec = 1'b0;
      case (opcode)
         R_TYPE:  illegal_dec = !(funct3 == 3'b000 || funct3 == 3'b111 ||
                                  funct3 == 3'b110 || funct3 == 3'b010);
         I_TYPE, LOAD, S_TYPE, B_TYPE, J_TYPE, JALR, LUI, AUI_PC:
                  illegal_dec = 1'b0;
         default: illegal_dec = 1'b1;
      endcase
   end

   // Sticky illegal-instruction flag
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) illegal_q <= 1'b0;
      else            illegal_q <= illegal_d;
   end

   assign illegal_instr = illegal_q;
`endif

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= FETCH;
      else            state_q <= state_d;
   end

   assign state    = state_q;
   assign br_taken = (funct3 == 3'b000 && alu_zero) || (funct3 == 3'b001 && !alu_zero);

   // Next-state and datapath control decode
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      result_src = 2'b00;
`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
      illegal_d  = illegal_q;
`endif
      case (state_q)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_rdy) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
            if (illegal_q || illegal_dec) illegal_d = 1'b1;
            else                          state_d   = EXECUTE;
`else
            state_d = EXECUTE;
`endif
         end
         EXECUTE: begin
            case (opcode)
               R_TYPE, I_TYPE: begin
                  alu_src_a = 2'b10;
                  alu_src_b = (opcode == R_TYPE) ? 2'b00 : 2'b01;
                  alu_op    = alu_decode(opcode, funct3, funct7_b5);
                  state_d   = RFL_WRB;
               end
               LOAD, S_TYPE: begin
                  alu_src_a = 2'b10;
                  alu_src_b = 2'b01;
                  state_d   = MEM_ACC;
               end
               B_TYPE: begin
                  alu_src_a = 2'b10;
                  alu_op    = ALU_SUB;
                  pc_we     = br_taken;
                  state_d   = FETCH;
               end
               J_TYPE, JALR: begin
                  pc_we     = 1'b1;
                  alu_src_a = 2'b01;
                  alu_src_b = 2'b10;
                  state_d   = RFL_WRB;
               end
               LUI, AUI_PC: begin
                  alu_src_a = 2'b01;
                  alu_src_b = 2'b01;
                  state_d   = RFL_WRB;
               end
               default: state_d = FETCH;
            endcase
         end
         MEM_ACC: begin
            mem_req  = 1'b1;
            addr_src = 1'b1;
            mem_we   = (opcode == S_TYPE);
            if (mem_rdy) state_d = (opcode == LOAD) ? RFL_WRB : FETCH;
         end
         RFL_WRB: begin
            rf_we   = 1'b1;
            state_d = FETCH;
            if (opcode == LOAD) begin
               result_src = 2'b01;
            end else if (opcode == J_TYPE || opcode == JALR) begin
               result_src = 2'b00;
               if (opcode == JALR) begin
                  alu_src_a = 2'b10;
                  alu_src_b = 2'b01;
               end
            end else begin
               result_src = 2'b10;
            end
         end
         default: state_d = FETCH;
      endcase
      // No architectural write may escape while reset is held
      if (!sys_rst_n) begin
         ir_we  = 1'b0;
         pc_we  = 1'b0;
         rf_we  = 1'b0;
         mem_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed table, corner sequences, random model.
module tb_cpu_ctrl_fsm;

   logic       sys_clk;
   logic       sys_rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       alu_zero;
   logic       mem_rdy;
   logic [2:0] state;
   logic       mem_req, mem_we, addr_src, ir_we, pc_we, rf_we;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [2:0] alu_op;
`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
   logic       illegal_instr;
`endif

   cpu_ctrl_fsm dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7_b5  (funct7_b5),
      .alu_zero   (alu_zero),
      .mem_rdy    (mem_rdy),
      .state      (state),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_src   (addr_src),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .rf_we      (rf_we),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_src (result_src)
`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
      ,
      .illegal_instr (illegal_instr)
`endif
   );

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JR  = 7'b1100111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   int n_cmp = 0;
   int n_bad = 0;
   int seen[$];

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Run one instruction from FETCH with mem_rdy high; gather per-instruction stats
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic b,
                            input logic z, output int cyc, output int alu_ex,
                            output int pc_ex, output int rf_cnt, output int mw_cnt);
      cyc = 0; alu_ex = -1; pc_ex = 0; rf_cnt = 0; mw_cnt = 0;
      seen.delete();
      do begin
         opcode = op; funct3 = f3; funct7_b5 = b; alu_zero = z; mem_rdy = 1'b1;
         #1;
         seen.push_back(int'(state));
         if (state == 3'd2) begin
            alu_ex = int'(alu_op);
            pc_ex += int'(pc_we);
         end
         rf_cnt += int'(rf_we);
         mw_cnt += int'(mem_we);
         cyc++;
         @(posedge sys_clk); #1;
      end while (state != 3'd0 && cyc < 12);
   endtask

   // Expected outputs from the architectural rules for a given phase of an instruction
   function automatic logic [17:0] model(input byte ph, input logic [6:0] op,
                                         input logic [2:0] f3, input logic b,
                                         input logic z, input logic rdy);
      int alu_of_f3[8] = '{0, 0, 5, 0, 0, 0, 3, 2};
      logic [2:0] st = 3'd0, alu = 3'd0;
      logic mreq = 1'b0, mwe = 1'b0, asrc = 1'b0, irwe = 1'b0, pcwe = 1'b0, rfwe = 1'b0;
      logic [1:0] sa = 2'd0, sb = 2'd0, rs = 2'd0;
      case (ph)
         "F": begin
            st = 3'd0; mreq = 1'b1; sb = 2'd2; rs = 2'd2; irwe = rdy; pcwe = rdy;
         end
         "D": begin
            st = 3'd1; sa = 2'd1; sb = 2'd1;
         end
         "E": begin
            st = 3'd2;
            if (op == OP_R || op == OP_I) begin
               sa = 2'd2; sb = (op == OP_R) ? 2'd0 : 2'd1;
               alu = (f3 == 3'b000 && op == OP_R && b) ? 3'd1 : 3'(alu_of_f3[f3]);
            end else if (op == OP_LD || op == OP_ST) begin
               sa = 2'd2; sb = 2'd1;
            end else if (op == OP_BR) begin
               sa = 2'd2; alu = 3'd1;
               pcwe = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
            end else if (op == OP_JAL || op == OP_JR) begin
               pcwe = 1'b1; sa = 2'd1; sb = 2'd2;
            end else if (op == OP_LUI || op == OP_AUI) begin
               sa = 2'd1; sb = 2'd1;
            end
         end
         "M": begin
            st = 3'd3; mreq = 1'b1; asrc = 1'b1; mwe = (op == OP_ST);
         end
         default: begin
            st = 3'd4; rfwe = 1'b1;
            rs = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JR) ? 2'd0 : 2'd2;
            if (op == OP_JR) begin sa = 2'd2; sb = 2'd1; end
         end
      endcase
      return {st, mreq, mwe, asrc, irwe, pcwe, rfwe, sa, sb, alu, rs};
   endfunction

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       b30;
      logic       z;
      int         cyc;
      int         alu;
      int         pc_ex;
      int         rf;
      int         mw;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int cyc, alu_ex, pc_ex, rf_cnt, mw_cnt, code, lowcnt, macc, wb_rs;
      logic [6:0] ops[$];
      logic [2:0] rf3[4] = '{3'b000, 3'b111, 3'b110, 3'b010};

      vecs.push_back('{"add",   OP_R,   3'b000, 1'b0, 1'b0, 4, 0, 0, 1, 0});
      vecs.push_back('{"sub",   OP_R,   3'b000, 1'b1, 1'b0, 4, 1, 0, 1, 0});
      vecs.push_back('{"and",   OP_R,   3'b111, 1'b0, 1'b0, 4, 2, 0, 1, 0});
      vecs.push_back('{"or",    OP_R,   3'b110, 1'b0, 1'b1, 4, 3, 0, 1, 0});
      vecs.push_back('{"slt",   OP_R,   3'b010, 1'b0, 1'b0, 4, 5, 0, 1, 0});
      vecs.push_back('{"addi",  OP_I,   3'b000, 1'b1, 1'b0, 4, 0, 0, 1, 0});
      vecs.push_back('{"beq_t", OP_BR,  3'b000, 1'b0, 1'b1, 3, 1, 1, 0, 0});
      vecs.push_back('{"bne_n", OP_BR,  3'b001, 1'b0, 1'b1, 3, 1, 0, 0, 0});
      vecs.push_back('{"bne_t", OP_BR,  3'b001, 1'b0, 1'b0, 3, 1, 1, 0, 0});
      vecs.push_back('{"sw",    OP_ST,  3'b010, 1'b0, 1'b0, 4, 0, 0, 0, 1});
      vecs.push_back('{"lw",    OP_LD,  3'b010, 1'b0, 1'b0, 5, 0, 0, 1, 0});
      vecs.push_back('{"jal",   OP_JAL, 3'b000, 1'b0, 1'b0, 4, 0, 1, 1, 0});
      vecs.push_back('{"jalr",  OP_JR,  3'b000, 1'b0, 1'b0, 4, 0, 1, 1, 0});
      vecs.push_back('{"lui",   OP_LUI, 3'b000, 1'b0, 1'b0, 4, 0, 0, 1, 0});
      vecs.push_back('{"auipc", OP_AUI, 3'b000, 1'b0, 1'b0, 4, 0, 0, 1, 0});
`ifndef CPU_ILLEGAL_INSTR_TRAP_EN
      vecs.push_back('{"nop_bad", OP_BAD, 3'b000, 1'b0, 1'b0, 3, 0, 0, 0, 0});
`endif

      // Reset: FETCH values visible immediately, write enables suppressed
      sys_rst_n = 1'b0; opcode = OP_R; funct3 = 3'b000; funct7_b5 = 1'b0;
      alu_zero = 1'b0; mem_rdy = 1'b1;
      #2;
      check("rst_state", int'(state), 0);
      check("rst_mem_req", int'(mem_req), 1);
      check("rst_addr_src", int'(addr_src), 0);
      check("rst_we", int'({ir_we, pc_we, rf_we, mem_we}), 0);
`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
      check("rst_illegal", int'(illegal_instr), 0);
`endif
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;

      // Directed instruction table
      for (int i = 0; i < vecs.size(); i++) begin
         run_instr(vecs[i].op, vecs[i].f3, vecs[i].b30, vecs[i].z,
                   cyc, alu_ex, pc_ex, rf_cnt, mw_cnt);
         check({vecs[i].name, "_cycles"}, cyc, vecs[i].cyc);
         check({vecs[i].name, "_alu_op"}, alu_ex, vecs[i].alu);
         check({vecs[i].name, "_pc_we_ex"}, pc_ex, vecs[i].pc_ex);
         check({vecs[i].name, "_rf_we_cnt"}, rf_cnt, vecs[i].rf);
         check({vecs[i].name, "_mem_we_cnt"}, mw_cnt, vecs[i].mw);
         if (i == 0) begin
            code = 0;
            foreach (seen[k]) code = code * 16 + seen[k];
            check("add_state_seq", code, 'h0124);
         end
      end

      // LOAD with three stalled cycles in MEM_ACC
      opcode = OP_LD; funct3 = 3'b010; funct7_b5 = 1'b0; alu_zero = 1'b0;
      lowcnt = 0; macc = 0; wb_rs = -1; cyc = 0;
      do begin
         if (state == 3'd3 && lowcnt < 3) begin
            mem_rdy = 1'b0; lowcnt++;
         end else begin
            mem_rdy = 1'b1;
         end
         #1;
         if (state == 3'd3 && mem_req && addr_src) macc++;
         if (state == 3'd4) wb_rs = int'(result_src);
         cyc++;
         @(posedge sys_clk); #1;
      end while (state != 3'd0 && cyc < 20);
      check("ld_stall_macc_cycles", macc, 4);
      check("ld_stall_wb_result_src", wb_rs, 1);
      check("ld_stall_total_cycles", cyc, 8);

      // Reset in RFL_WRB aborts the write with mem_rdy high
      opcode = OP_R; funct3 = 3'b000; mem_rdy = 1'b1;
      for (int i = 0; i < 5 && state != 3'd4; i++) begin
         @(posedge sys_clk); #1;
      end
      check("pre_rst_state", int'(state), 4);
      #2 sys_rst_n = 1'b0;
      #1;
      check("mid_rst_state", int'(state), 0);
      check("mid_rst_we", int'({ir_we, pc_we, rf_we, mem_we}), 0);
      check("mid_rst_mem_req", int'({mem_req, addr_src}), 2);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;

`ifdef CPU_ILLEGAL_INSTR_TRAP_EN
      // Illegal opcode traps in DECODE and stays there
      opcode = OP_BAD; mem_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge sys_clk); #1;
      end
      check("illegal_state", int'(state), 1);
      check("illegal_flag", int'(illegal_instr), 1);
      check("illegal_we", int'({mem_req, ir_we, pc_we, rf_we, mem_we}), 0);
      opcode = OP_R;
      #2 sys_rst_n = 1'b0;
      #1;
      check("illegal_cleared", int'(illegal_instr), 0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
`endif

      // Random instruction stream against the phase model
      ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI, OP_AUI};
`ifndef CPU_ILLEGAL_INSTR_TRAP_EN
      ops.push_back(OP_BAD);
`endif
      for (int k = 0; k < 300; k++) begin
         logic [6:0] op;
         logic [2:0] f3;
         logic       b;
         byte        phases[$];
         int         pos;
         op = ops[$urandom_range(0, ops.size() - 1)];
         f3 = (op == OP_R) ? rf3[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
         b  = 1'($urandom_range(0, 1));
         phases = '{"F", "D", "E"};
         if (op == OP_LD) begin
            phases.push_back("M"); phases.push_back("W");
         end else if (op == OP_ST) begin
            phases.push_back("M");
         end else if (op != OP_BR && op != OP_BAD) begin
            phases.push_back("W");
         end
         pos = 0;
         while (pos < phases.size()) begin
            logic rdy, z;
            logic [17:0] exp, act;
            rdy = ($urandom_range(0, 3) != 0);
            z   = 1'($urandom_range(0, 1));
            if (phases[pos] == "F") begin
               opcode = 7'($urandom_range(0, 127)); funct3 = 3'($urandom_range(0, 7));
               funct7_b5 = 1'($urandom_range(0, 1));
            end else begin
               opcode = op; funct3 = f3; funct7_b5 = b;
            end
            alu_zero = z; mem_rdy = rdy;
            #1;
            exp = model(phases[pos], op, f3, b, z, rdy);
            act = {state, mem_req, mem_we, addr_src, ir_we, pc_we, rf_we,
                   alu_src_a, alu_src_b, alu_op, result_src};
            check($sformatf("rand_i%0d_%s", k, string'(phases[pos])), int'(act), int'(exp));
            if (!((phases[pos] == "F" || phases[pos] == "M") && !rdy)) pos++;
            @(posedge sys_clk); #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
